traffic_sequencer: RTL and testbench
====================================

# traffic_sequencer

Moore-style light controller that sequences the intersection by selecting which programmable interval (base, extension, yellow) the timing-parameter block presents, loading that duration into a seconds countdown, and advancing main/side/walk lamps on expiry. It sits between the 1 Hz tick generator, the sensor/walk inputs and the lamp drivers, and owns the `interval` select into the timing-parameter block. It reads that block's `value` output, which is registered with one cycle of latency.

## Interface
- No parameters. Durations come from `value`; defaults are t_base=6, t_ext=3, t_yel=2.
- `clock` in 1: system clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `one_hz_enable` in 1: one-cycle tick pulse; each pulse is one second of countdown.
- `sensor` in 1: side-street traffic present (level, already synchronised).
- `walk_request` in 1: pedestrian request pulse or level (already synchronised).
- `prog_sync` in 1: parameter-program strobe; the same signal also feeds the timing-parameter block.
- `value` in 4: duration for the current `interval`, valid one cycle after `interval` changes.
- `interval` out 2: register; 00=base, 01=ext, 10=yellow; 11 is never driven.
- `main_light` out 3: {red,yellow,green}, decoded from state.
- `side_light` out 3: {red,yellow,green}, decoded from state.
- `walk_light` out 1: walk lamp, decoded from state.
- `state` out 3: current state code, for debug/LED.

## Operation
- States, each listed as code, lamps, interval and exit:
  - MG_BASE: code 0; main G, side R; interval 00. On expiry, go to MAIN_YEL if `sensor`=1, else to MG_EXT.
  - MG_EXT: code 1; main G, side R; interval 01. On expiry, go to MAIN_YEL.
  - MAIN_YEL: code 2; main Y, side R; interval 10. On expiry, go to WALK if walk_latched, else to SIDE_GREEN.
  - WALK: code 3; main R, side R, walk=1; interval 01. On expiry, go to SIDE_GREEN.
  - SIDE_GREEN: code 4; main R, side G; interval 00. On expiry, go to SG_EXT if `sensor`=1, else to SIDE_YEL.
  - SG_EXT: code 5; main R, side G; interval 01. On expiry, go to SIDE_YEL.
  - SIDE_YEL: code 6; main R, side Y; interval 10. On expiry, go to MG_BASE.
  - Code 7 is illegal and goes to MG_BASE on the next edge.
- `sensor` is sampled only on the expiry edge.
- walk_latched:
  - Set on any cycle with `walk_request`=1.
  - Cleared on the edge entering WALK.
  - If set and clear coincide, set wins.
- Countdown: 4-bit counter plus a two-phase load sequencer (WAIT, LOAD), both entered on every state entry.
- `interval` is updated on the same edge as the state register.
- `value` 0 is loaded as 1, so every state lasts at least one tick.
- `prog_sync`=1 has the same effect as reset, except walk_latched is preserved.
- `reset` has priority over `prog_sync`.

## Timing
- Reset values:
  - state=MG_BASE, interval=00, counter=0, load phase=WAIT, walk_latched=0.
  - main_light=001, side_light=100, walk_light=0.
- Entry cycle E (WAIT): ticks ignored.
- Cycle E+1 (LOAD): `value` is now valid; counter <= max(value,1) at the end of E+1; ticks ignored.
- From E+2: each `one_hz_enable` decrements the counter.
- Expiry: a tick with counter==1. The state and `interval` change on that same edge.
- Dwell time is 2 cycles + N ticks. With a tick every cycle, a state lasts N+2 cycles.
- Lamps change on the same edge as the state (combinational decode, no extra latency).
- No tick arrives during a countdown: the state holds indefinitely.

## Test plan
- Defaults, tick every cycle, sensor=0, no walk. Required response:
  - State sequence 0,1,2,4,6,0 with dwell 8,5,4,8,4 cycles (29-cycle period).
  - interval sequence 00,01,10,00,10.
- sensor=1 held. Required response:
  - State sequence 0,2,4,5,6.
  - MG_EXT is skipped; SG_EXT is taken with a 5-cycle dwell.
- Single-cycle walk_request pulse during MG_BASE. Required response:
  - After MAIN_YEL: WALK with main=100, side=100, walk=1 for 5 cycles, then SIDE_GREEN.
  - Next lap skips WALK.
- Program t_yel=0 via prog_sync pulse. Required response:
  - Controller restarts in MG_BASE.
  - MAIN_YEL then lasts 3 cycles (0 loaded as 1).
- Ticks every 4th cycle; assert reset mid-countdown in SIDE_GREEN. Required response:
  - Next cycle: state=0, interval=00, lamps at reset values.
  - Ticks coinciding with WAIT/LOAD do not decrement the counter.
- Force state code 7 via bench. Required response: state=MG_BASE on the next edge.

Source files
------------

// File: rtl/traffic_sequencer_if.sv
// Signal bundle between the traffic sequencer and its surroundings:
// tick/sensor/walk/program inputs, the timing-parameter select/value pair and the lamp drives.
interface traffic_sequencer_if;
  logic       one_hz_enable;
  logic       sensor;
  logic       walk_request;
  logic       prog_sync;
  logic [3:0] value;
  logic [1:0] interval;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk_light;
  logic [2:0] state;

  // master is the sequencer itself; slave is whatever drives its inputs and watches its lamps
  modport master (
    input  one_hz_enable, sensor, walk_request, prog_sync, value,
    output interval, main_light, side_light, walk_light, state
  );

  modport slave (
    output one_hz_enable, sensor, walk_request, prog_sync, value,
    input  interval, main_light, side_light, walk_light, state
  );
endinterface

// File: rtl/traffic_sequencer.sv
// Moore intersection controller: selects a timing interval, loads its duration into a
// seconds countdown and steps the main/side/walk lamps each time the countdown expires.
module traffic_sequencer (
  input logic                 clock,
  input logic                 reset,
  traffic_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    MG_BASE    = 3'd0,
    MG_EXT     = 3'd1,
    MAIN_YEL   = 3'd2,
    WALK       = 3'd3,
    SIDE_GREEN = 3'd4,
    SG_EXT     = 3'd5,
    SIDE_YEL   = 3'd6,
    ILLEGAL    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    PH_WAIT  = 2'd0,
    PH_LOAD  = 2'd1,
    PH_COUNT = 2'd2
  } phase_t;

  localparam logic [1:0] INT_BASE = 2'b00;
  localparam logic [1:0] INT_EXT  = 2'b01;
  localparam logic [1:0] INT_YEL  = 2'b10;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  // The state register holds the raw code so a corrupted value (7) is visible and recoverable.
  logic [2:0] state_q;
  state_t     cur_state;
  state_t     state_d;
  state_t     expiry_target;
  logic [1:0] interval_q, interval_d;
  logic [3:0] counter_q, counter_d;
  phase_t     phase_q, phase_d;
  logic       walk_latched_q, walk_latched_d;
  logic [2:0] main_lamp, side_lamp;
  logic       walk_lamp;

  assign cur_state = state_t'(state_q);

  function automatic logic [1:0] interval_for(input state_t s);
    case (s)
      MG_EXT, WALK, SG_EXT: interval_for = INT_EXT;
      MAIN_YEL, SIDE_YEL:   interval_for = INT_YEL;
      default:              interval_for = INT_BASE;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= MG_BASE;
      interval_q     <= INT_BASE;
      counter_q      <= 4'd0;
      phase_q        <= PH_WAIT;
      walk_latched_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      interval_q     <= interval_d;
      counter_q      <= counter_d;
      phase_q        <= phase_d;
      walk_latched_q <= walk_latched_d;
    end
  end

  // Where each state goes when its countdown runs out; sensor only matters on that edge.
  always_comb begin
    expiry_target = MG_BASE;
    case (cur_state)
      MG_BASE:    expiry_target = bus.sensor ? MAIN_YEL : MG_EXT;
      MG_EXT:     expiry_target = MAIN_YEL;
      MAIN_YEL:   expiry_target = walk_latched_q ? WALK : SIDE_GREEN;
      WALK:       expiry_target = SIDE_GREEN;
      SIDE_GREEN: expiry_target = bus.sensor ? SG_EXT : SIDE_YEL;
      SG_EXT:     expiry_target = SIDE_YEL;
      SIDE_YEL:   expiry_target = MG_BASE;
      default:    expiry_target = MG_BASE;
    endcase
  end

  always_comb begin
    state_d        = cur_state;
    interval_d     = interval_q;
    counter_d      = counter_q;
    phase_d        = phase_q;
    walk_latched_d = walk_latched_q;

    if (cur_state == ILLEGAL) begin
      state_d    = MG_BASE;
      interval_d = INT_BASE;
      counter_d  = 4'd0;
      phase_d    = PH_WAIT;
    end else begin
      // WAIT gives the parameter block a cycle to present the new interval's value.
      case (phase_q)
        PH_WAIT: phase_d = PH_LOAD;
        PH_LOAD: begin
          counter_d = (bus.value == 4'd0) ? 4'd1 : bus.value;
          phase_d   = PH_COUNT;
        end
        PH_COUNT: begin
          if (bus.one_hz_enable) begin
            counter_d = counter_q - 4'd1;
            if (counter_q == 4'd1) begin
              state_d    = expiry_target;
              interval_d = interval_for(expiry_target);
              phase_d    = PH_WAIT;
            end
          end
        end
        default: phase_d = PH_WAIT;
      endcase
    end

    if (bus.prog_sync) begin
      state_d    = MG_BASE;
      interval_d = INT_BASE;
      counter_d  = 4'd0;
      phase_d    = PH_WAIT;
    end

    // A request arriving on the very edge that enters WALK must not be lost.
    if ((state_d == WALK) && (cur_state != WALK)) begin
      walk_latched_d = 1'b0;
    end
    if (bus.walk_request) begin
      walk_latched_d = 1'b1;
    end
  end

  always_comb begin
    main_lamp = LAMP_RED;
    side_lamp = LAMP_RED;
    walk_lamp = 1'b0;
    case (cur_state)
      MG_BASE, MG_EXT:    main_lamp = LAMP_GREEN;
      MAIN_YEL:           main_lamp = LAMP_YELLOW;
      WALK:               walk_lamp = 1'b1;
      SIDE_GREEN, SG_EXT: side_lamp = LAMP_GREEN;
      SIDE_YEL:           side_lamp = LAMP_YELLOW;
      default: begin
        main_lamp = LAMP_RED;
        side_lamp = LAMP_RED;
      end
    endcase
  end

  assign bus.state      = state_q;
  assign bus.interval   = interval_q;
  assign bus.main_light = main_lamp;
  assign bus.side_light = side_lamp;
  assign bus.walk_light = walk_lamp;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Bench for traffic_sequencer: directed laps plus random stimulus, checked every cycle
// against a dwell-time model of the intersection and a stand-in timing-parameter block.
module tb_traffic_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  traffic_sequencer_if bus ();

  traffic_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Timing-parameter block stand-in: value is registered, one cycle behind interval.
  logic [3:0] t_base = 4'd6;
  logic [3:0] t_ext  = 4'd3;
  logic [3:0] t_yel  = 4'd2;

  always_ff @(posedge clock) begin
    case (bus.interval)
      2'b00:   bus.value <= t_base;
      2'b01:   bus.value <= t_ext;
      2'b10:   bus.value <= t_yel;
      default: bus.value <= 4'd0;
    endcase
  end

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: state code, cycles since entry (saturating at 2), ticks counted, duration.
  int m_state = 0;
  int m_age   = 0;
  int m_ticks = 0;
  int m_dur   = 1;
  bit m_walk  = 1'b0;

  int exp_interval [7] = '{0, 1, 2, 1, 0, 1, 2};
  int exp_main     [7] = '{1, 1, 2, 4, 4, 4, 4};
  int exp_side     [7] = '{4, 4, 4, 4, 1, 1, 2};
  int exp_walk     [7] = '{0, 0, 0, 1, 0, 0, 0};

  int lap_state [8];
  int lap_dur   [8];
  int lap_int   [8];
  int lap_n;

  function automatic int next_of(input int s, input bit sens, input bit walk);
    case (s)
      0:       return sens ? 2 : 1;
      1:       return 2;
      2:       return walk ? 3 : 4;
      3:       return 4;
      4:       return sens ? 5 : 6;
      5:       return 6;
      default: return 0;
    endcase
  endfunction

  function automatic int duration_of(input int s);
    int raw;
    case (exp_interval[s])
      0:       raw = int'(t_base);
      1:       raw = int'(t_ext);
      default: raw = int'(t_yel);
    endcase
    return (raw < 1) ? 1 : raw;
  endfunction

  task automatic modelStep(input bit tick, input bit sens, input bit walk, input bit prog, input bit rst);
    int  ns;
    bit  entering_walk;
    entering_walk = 1'b0;
    if (rst) begin
      m_state = 0; m_age = 0; m_ticks = 0; m_walk = 1'b0;
      return;
    end
    if (prog) begin
      m_state = 0; m_age = 0; m_ticks = 0;
      if (walk) m_walk = 1'b1;
      return;
    end
    if (m_age >= 2 && tick && (m_ticks + 1 == m_dur)) begin
      ns = next_of(m_state, sens, m_walk);
      entering_walk = (ns == 3);
      m_state = ns; m_age = 0; m_ticks = 0;
    end else begin
      if (m_age >= 2 && tick) m_ticks++;
      if (m_age == 1) m_dur = duration_of(m_state);
      if (m_age < 2) m_age++;
    end
    if (entering_walk) m_walk = 1'b0;
    if (walk) m_walk = 1'b1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit tick, input bit sens, input bit walk, input bit prog, input bit rst);
    @(negedge clock);
    bus.one_hz_enable = tick;
    bus.sensor        = sens;
    bus.walk_request  = walk;
    bus.prog_sync     = prog;
    reset             = rst;
    @(posedge clock);
    modelStep(tick, sens, walk, prog, rst);
    #1;
  endtask

  task automatic checkOutput();
    check("state",      {5'd0, bus.state},      8'(m_state));
    check("interval",   {6'd0, bus.interval},   8'(exp_interval[m_state]));
    check("main_light", {5'd0, bus.main_light}, 8'(exp_main[m_state]));
    check("side_light", {5'd0, bus.side_light}, 8'(exp_side[m_state]));
    check("walk_light", {7'd0, bus.walk_light}, 8'(exp_walk[m_state]));
  endtask

  // Runs from a state-entry cycle with a tick every cycle, logging each state left and its dwell.
  task automatic recordLap(input int edges, input bit sens, input bit walk_first);
    int prev, run, cur_int;
    prev = int'(bus.state); run = 1; cur_int = int'(bus.interval); lap_n = 0;
    for (int e = 0; e < edges; e++) begin
      applyStimulus(1'b1, sens, walk_first && (e == 0), 1'b0, 1'b0);
      checkOutput();
      if (int'(bus.state) != prev) begin
        if (lap_n < 8) begin
          lap_state[lap_n] = prev; lap_dur[lap_n] = run; lap_int[lap_n] = cur_int;
        end
        lap_n++;
        prev = int'(bus.state); run = 1; cur_int = int'(bus.interval);
      end else begin
        run++;
      end
    end
  endtask

  task automatic checkLapEntry(input string tag, input int idx, input int s, input int d, input int iv);
    check({tag, "_state"},    8'(lap_state[idx]), 8'(s));
    check({tag, "_dwell"},    8'(lap_dur[idx]),   8'(d));
    check({tag, "_interval"}, 8'(lap_int[idx]),   8'(iv));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  dwell;
    bit  found;
    bus.one_hz_enable = 1'b0;
    bus.sensor        = 1'b0;
    bus.walk_request  = 1'b0;
    bus.prog_sync     = 1'b0;

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput();

    // Default lap, no sensor, no walk.
    recordLap(29, 1'b0, 1'b0);
    check("lap_default_count", 8'(lap_n), 8'd5);
    checkLapEntry("def0", 0, 0, 8, 0);
    checkLapEntry("def1", 1, 1, 5, 1);
    checkLapEntry("def2", 2, 2, 4, 2);
    checkLapEntry("def3", 3, 4, 8, 0);
    checkLapEntry("def4", 4, 6, 4, 2);
    check("lap_default_wrap", {5'd0, bus.state}, 8'd0);

    // Sensor held: MG_EXT skipped, SG_EXT taken.
    recordLap(29, 1'b1, 1'b0);
    check("lap_sensor_count", 8'(lap_n), 8'd5);
    checkLapEntry("sen0", 0, 0, 8, 0);
    checkLapEntry("sen1", 1, 2, 4, 2);
    checkLapEntry("sen2", 2, 4, 8, 0);
    checkLapEntry("sen3", 3, 5, 5, 1);
    checkLapEntry("sen4", 4, 6, 4, 2);

    // Walk pulse in MG_BASE, then a lap without WALK.
    recordLap(34, 1'b0, 1'b1);
    check("lap_walk_count", 8'(lap_n), 8'd6);
    checkLapEntry("walk2", 2, 2, 4, 2);
    checkLapEntry("walk3", 3, 3, 5, 1);
    checkLapEntry("walk4", 4, 4, 8, 0);
    recordLap(29, 1'b0, 1'b0);
    check("lap_nowalk_count", 8'(lap_n), 8'd5);
    check("lap_nowalk_skip",  8'(lap_state[3]), 8'd4);

    // Zero yellow time programmed: restart in MG_BASE, yellow lasts 3 cycles.
    t_yel = 4'd0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput();
    check("prog_restart_state", {5'd0, bus.state}, 8'd0);
    recordLap(27, 1'b0, 1'b0);
    check("lap_prog_count", 8'(lap_n), 8'd5);
    checkLapEntry("prog2", 2, 2, 3, 2);
    checkLapEntry("prog4", 4, 6, 3, 2);
    t_yel = 4'd2;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput();

    for (int c = 0; c < 300; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0), 1'b0, 1'b0);
      checkOutput();
    end

    // Tick every 4th cycle until mid-countdown in SIDE_GREEN, then reset.
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      applyStimulus((c % 4) == 0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput();
      if (m_state == 4 && m_ticks >= 1) found = 1'b1;
    end
    check("reached_side_green", {7'd0, found}, 8'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput();
    check("mid_reset_state",    {5'd0, bus.state},      8'd0);
    check("mid_reset_interval", {6'd0, bus.interval},   8'd0);
    check("mid_reset_main",     {5'd0, bus.main_light}, 8'd1);
    check("mid_reset_side",     {5'd0, bus.side_light}, 8'd4);
    check("mid_reset_walk",     {7'd0, bus.walk_light}, 8'd0);

    // Ticks in WAIT and LOAD must be ignored: 6 counted ticks 4 cycles apart give 23 cycles.
    dwell = 0;
    for (int k = 0; k < 80 && dwell == 0; k++) begin
      applyStimulus((k < 2) || (((k - 2) % 4) == 0), 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput();
      if (bus.state != 3'd0) dwell = k + 1;
    end
    check("wait_load_ticks_ignored", 8'(dwell), 8'd23);

    // Illegal code recovery.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput();
    @(negedge clock);
    force dut.state_q = 3'd7;
    #1;
    check("forced_state", {5'd0, bus.state}, 8'd7);
    release dut.state_q;
    @(posedge clock);
    #1;
    check("illegal_recover_state",    {5'd0, bus.state},    8'd0);
    check("illegal_recover_interval", {6'd0, bus.interval}, 8'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
